regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
// Shares the register file's single write port (we/rd/rd_din) between the ALU
// writeback and the load writeback paths, using round-robin arbitration. Keeps a
// per-register busy scoreboard for outstanding loads and raises stall when the
// decode-stage source registers (rs1/rs2) are busy. Sits between execute/LSU and
// the register file, and drives the regfile write inputs from registered outputs.
// PARAMETERS
// BITS   8  data width of register values
// RBITS  3  register index width
// NREG   8  number of architectural registers (index 0 hardwired to zero)
// PORTS
// clk           in   1      system clock, all state on rising edge
// reset         in   1      synchronous, active-high reset
// run           in   1      global enable; 0 freezes all state, no grants/writes
// alu_valid     in   1      ALU writeback request
// alu_rd        in   RBITS  ALU destination register
// alu_data      in   BITS   ALU result
// alu_ready     out  1      ALU request accepted this cycle (comb.)
// ld_issue      in   1      load issued to memory; mark ld_issue_rd busy
// ld_issue_rd   in   RBITS  load destination register
// ld_issue_ok   out  1      issue permitted: run & ~busy[ld_issue_rd] (comb.)
// ld_valid      in   1      load data return request
// ld_rd         in   RBITS  load destination register
// ld_data       in   BITS   load data
// ld_ready      out  1      load return accepted this cycle (comb.)
// rs1, rs2      in   RBITS  decode-stage source indices
// stall         out  1      rs1 or rs2 nonzero and busy (comb.)
// rf_we         out  1      regfile write enable (registered)
// rf_rd         out  RBITS  regfile write index (registered)
// rf_din        out  BITS   regfile write data (registered)
// BEHAVIOUR
// - Reset: rf_we=0, rf_rd=0, rf_din=0, busy[all]=0, rr_ptr=ALU. Applies mid-op;
//   pending loads are forgotten, and any in-flight write in the output reg is dropped.
// - run=0: alu_ready=ld_ready=ld_issue_ok=0, rf_we<=0, busy and rr_ptr held.
// - Arbitration (comb.): if only one path is valid, it is granted. If both are valid,
//   the grant goes to rr_ptr. A handshake completes when valid&ready in the same cycle.
// - rr_ptr: after any grant, points at the path NOT granted. No grant -> unchanged.
// - Output reg (1-cycle latency): on grant, rf_we<=(rd!=0), rf_rd<=rd, rf_din<=data;
//   with no grant, rf_we<=0 and rf_rd/rf_din hold. Regfile commits on the next edge,
//   so data is readable 2 edges after the handshake.
// - rd==0 write: handshake completes and rr_ptr rotates, but rf_we stays 0.
// - Scoreboard set: ld_issue & ld_issue_ok & ld_issue_rd!=0 -> busy[rd]<=1.
//   ld_issue while ~ld_issue_ok: ignored (upstream must hold). Index 0 never busy.
// - Scoreboard clear: at the edge where rf_we=1 and the write came from the load
//   path -> busy[rf_rd]<=0. The clear coincides with the regfile commit.
// - Set and clear on the same register in the same cycle: set wins (busy stays 1).
// - ALU write to a busy register: write proceeds, busy unchanged. Decode stall
//   prevents this case in normal flow.
// - stall = (rs1!=0 & busy[rs1]) | (rs2!=0 & busy[rs2]). Pure comb., valid when run=0.
// - Inputs with valid=0 are don't-care. Ready never depends on data/rd.
// TESTING
// - Reset, then ALU rd=2 data=0x5A alone -> alu_ready=1; next cycle rf_we=1,
//   rf_rd=2, rf_din=0x5A; the cycle after that, rf_we=0.
// - Both valid for 4 cycles after reset (ALU rd=1/0x11, LD rd=3/0x33) -> grants
//   ALU,LD,ALU,LD; rf_rd sequence 1,3,1,3.
// - ld_issue rd=3, then rs1=3 -> stall=1; second ld_issue rd=3 -> ld_issue_ok=0;
//   ld return rd=3 0x77 -> stall drops the cycle after rf_we=1.
// - ALU rd=0 data=0xFF -> alu_ready=1, rf_we stays 0, rr_ptr flips to LD.
// - Busy rd=1 with the load return granted and ld_issue rd=1 in the same cycle
//   -> busy[1] remains 1, stall for rs2=1.
// - Mid-transfer run=0 -> no ready, rf_we=0, busy held. Reset with busy[2]=1
//   -> busy clears, stall=0 for rs1=2, rf_we=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU and load
// writeback, plus a per-register busy scoreboard that stalls decode on pending loads.
module regfile_wb_arbiter #(
    parameter int unsigned BITS  = 8,
    parameter int unsigned RBITS = 3,
    parameter int unsigned NREG  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             alu_valid,
    input  logic [RBITS-1:0] alu_rd,
    input  logic [BITS-1:0]  alu_data,
    output logic             alu_ready,
    input  logic             ld_issue,
    input  logic [RBITS-1:0] ld_issue_rd,
    output logic             ld_issue_ok,
    input  logic             ld_valid,
    input  logic [RBITS-1:0] ld_rd,
    input  logic [BITS-1:0]  ld_data,
    output logic             ld_ready,
    input  logic [RBITS-1:0] rs1,
    input  logic [RBITS-1:0] rs2,
    output logic             stall,
    output logic             rf_we,
    output logic [RBITS-1:0] rf_rd,
    output logic [BITS-1:0]  rf_din
);

    typedef enum logic {
        RR_ALU = 1'b0,
        RR_LD  = 1'b1
    } rr_e;

    typedef struct packed {
        logic             we;
        logic             from_ld;
        logic [RBITS-1:0] rd;
        logic [BITS-1:0]  din;
    } wb_t;

    rr_e             rr_q, rr_d;
    wb_t             wb_q, wb_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            grant_alu_c, grant_ld_c;

    // Single requester wins outright; on contention rr_q picks the winner.
    always_comb begin
        grant_alu_c = run & alu_valid & (~ld_valid | (rr_q == RR_ALU));
        grant_ld_c  = run & ld_valid & (~alu_valid | (rr_q == RR_LD));
    end

    assign alu_ready   = grant_alu_c;
    assign ld_ready    = grant_ld_c;
    assign ld_issue_ok = run & ~busy_q[ld_issue_rd];
    assign stall       = ((rs1 != RBITS'(0)) & busy_q[rs1]) |
                         ((rs2 != RBITS'(0)) & busy_q[rs2]);

    assign rf_we  = wb_q.we;
    assign rf_rd  = wb_q.rd;
    assign rf_din = wb_q.din;

    // Next-state: pointer rotation, output register, scoreboard clear then set.
    always_comb begin
        rr_d    = rr_q;
        wb_d    = wb_q;
        wb_d.we = 1'b0;
        busy_d  = busy_q;
        if (run) begin
            if (grant_alu_c) begin
                wb_d.we      = (alu_rd != RBITS'(0));
                wb_d.from_ld = 1'b0;
                wb_d.rd      = alu_rd;
                wb_d.din     = alu_data;
                rr_d         = RR_LD;
            end else if (grant_ld_c) begin
                wb_d.we      = (ld_rd != RBITS'(0));
                wb_d.from_ld = 1'b1;
                wb_d.rd      = ld_rd;
                wb_d.din     = ld_data;
                rr_d         = RR_ALU;
            end
            if (wb_q.we && wb_q.from_ld) begin
                busy_d[wb_q.rd] = 1'b0;
            end
            // Set after clear so a same-register collision leaves the entry busy.
            if (ld_issue && ld_issue_ok && (ld_issue_rd != RBITS'(0))) begin
                busy_d[ld_issue_rd] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q   <= RR_ALU;
            wb_q   <= '0;
            busy_q <= '0;
        end else begin
            rr_q   <= rr_d;
            wb_q   <= wb_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Vector-table bench for regfile_wb_arbiter; expected regfile writes are queued at
// drive time and compared one cycle later against the registered outputs.
module tb_regfile_wb_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       alu_valid;
    logic [2:0] alu_rd;
    logic [7:0] alu_data;
    logic       alu_ready;
    logic       ld_issue;
    logic [2:0] ld_issue_rd;
    logic       ld_issue_ok;
    logic       ld_valid;
    logic [2:0] ld_rd;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic [2:0] rs1, rs2;
    logic       stall;
    logic       rf_we;
    logic [2:0] rf_rd;
    logic [7:0] rf_din;

    regfile_wb_arbiter #(.BITS(8), .RBITS(3), .NREG(8)) dut (
        .clk(clk), .reset(reset), .run(run),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_issue_ok(ld_issue_ok),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .rs1(rs1), .rs2(rs2), .stall(stall),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_din(rf_din)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       run, av;
        logic [2:0] ard;
        logic [7:0] adat;
        logic       lv;
        logic [2:0] lrd;
        logic [7:0] ldat;
        logic       iss;
        logic [2:0] isrd, rs1, rs2;
        logic       e_ar, e_lr, e_ok, e_st;
    } vec_t;

    typedef struct packed {
        logic       we;
        logic [2:0] rd;
        logic [7:0] din;
    } wr_t;

    vec_t       tbl[26];
    wr_t        exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] last_rd  = '0;
    logic [7:0] last_din = '0;

    function automatic vec_t mk(input logic r, av, input logic [2:0] ard, input logic [7:0] adat,
                                input logic lv, input logic [2:0] lrd, input logic [7:0] ldat,
                                input logic iss, input logic [2:0] isrd, rs1, rs2,
                                input logic ar, lr, ok, st);
        vec_t v;
        v.run = r;   v.av = av;   v.ard = ard;   v.adat = adat;
        v.lv = lv;   v.lrd = lrd; v.ldat = ldat;
        v.iss = iss; v.isrd = isrd; v.rs1 = rs1; v.rs2 = rs2;
        v.e_ar = ar; v.e_lr = lr; v.e_ok = ok;  v.e_st = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        run = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        ld_issue = 1'b0; ld_issue_rd = '0; rs1 = '0; rs2 = '0;
    endtask

    // Drive one vector, check comb outputs, queue the write, check it after the edge.
    task automatic step(input int idx);
        vec_t v;
        wr_t  w;
        v = tbl[idx];
        run = v.run; alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
        ld_valid = v.lv; ld_rd = v.lrd; ld_data = v.ldat;
        ld_issue = v.iss; ld_issue_rd = v.isrd; rs1 = v.rs1; rs2 = v.rs2;
        #1;
        chk($sformatf("alu_ready[%0d]", idx), 32'(alu_ready), 32'(v.e_ar));
        chk($sformatf("ld_ready[%0d]", idx), 32'(ld_ready), 32'(v.e_lr));
        chk($sformatf("ld_issue_ok[%0d]", idx), 32'(ld_issue_ok), 32'(v.e_ok));
        chk($sformatf("stall[%0d]", idx), 32'(stall), 32'(v.e_st));
        if (v.e_ar) begin
            w.we = (v.ard != 3'd0); w.rd = v.ard; w.din = v.adat;
        end else if (v.e_lr) begin
            w.we = (v.lrd != 3'd0); w.rd = v.lrd; w.din = v.ldat;
        end else begin
            w.we = 1'b0; w.rd = last_rd; w.din = last_din;
        end
        last_rd  = w.rd;
        last_din = w.din;
        exp_q.push_back(w);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard[%0d]: got empty queue expected one entry", idx);
        end else begin
            w = exp_q.pop_front();
            chk($sformatf("rf_we[%0d]", idx), 32'(rf_we), 32'(w.we));
            chk($sformatf("rf_rd[%0d]", idx), 32'(rf_rd), 32'(w.rd));
            chk($sformatf("rf_din[%0d]", idx), 32'(rf_din), 32'(w.din));
        end
    endtask

    initial begin
        //            run av ard  adat   lv lrd ldat   is isrd rs1 rs2  ar lr ok st
        tbl[0]  = mk(1, 1, 3'd1, 8'h11, 1, 3'd3, 8'h33, 0, 3'd0, 3'd0, 3'd0, 1, 0, 1, 0);
        tbl[1]  = mk(1, 1, 3'd1, 8'h11, 1, 3'd3, 8'h33, 0, 3'd0, 3'd0, 3'd0, 0, 1, 1, 0);
        tbl[2]  = mk(1, 1, 3'd1, 8'h11, 1, 3'd3, 8'h33, 0, 3'd0, 3'd0, 3'd0, 1, 0, 1, 0);
        tbl[3]  = mk(1, 1, 3'd1, 8'h11, 1, 3'd3, 8'h33, 0, 3'd0, 3'd0, 3'd0, 0, 1, 1, 0);
        tbl[4]  = mk(1, 1, 3'd2, 8'h5A, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 3'd0, 1, 0, 1, 0);
        tbl[5]  = mk(1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, 0);
        tbl[6]  = mk(1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 3'd3, 3'd3, 3'd0, 0, 0, 1, 0);
        tbl[7]  = mk(1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 3'd3, 3'd3, 3'd0, 0, 0, 0, 1);
        tbl[8]  = mk(1, 0, 3'd0, 8'h00, 1, 3'd3, 8'h77, 0, 3'd0, 3'd3, 3'd0, 0, 1, 1, 1);
        tbl[9]  = mk(1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 3'd3, 3'd0, 0, 0, 1, 1);
        tbl[10] = mk(1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 3'd3, 3'd0, 0, 0, 1, 0);
        tbl[11] = mk(1, 1, 3'd0, 8'hFF, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 3'd0, 1, 0, 1, 0);
        tbl[12] = mk(1, 1, 3'd4, 8'h44, 1, 3'd5, 8'h55, 0, 3'd0, 3'd0, 3'd0, 0, 1, 1, 0);
        tbl[13] = mk(1, 0, 3'd0, 8'h00, 1, 3'd1, 8'h21, 0, 3'd0, 3'd0, 3'd1, 0, 1, 1, 0);
        tbl[14] = mk(1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 3'd1, 3'd0, 3'd1, 0, 0, 1, 0);
        tbl[15] = mk(1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 3'd1, 0, 0, 1, 1);
        tbl[16] = mk(1, 1, 3'd6, 8'h66, 0, 3'd0, 8'h00, 1, 3'd1, 3'd0, 3'd1, 1, 0, 0, 1);
        tbl[17] = mk(0, 1, 3'd2, 8'h22, 1, 3'd1, 8'h99, 0, 3'd0, 3'd0, 3'd1, 0, 0, 0, 1);
        tbl[18] = mk(1, 1, 3'd2, 8'h22, 1, 3'd1, 8'h99, 0, 3'd0, 3'd0, 3'd1, 0, 1, 1, 1);
        tbl[19] = mk(1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 3'd1, 0, 0, 1, 1);
        tbl[20] = mk(1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 3'd1, 0, 0, 1, 0);
        tbl[21] = mk(1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 3'd2, 3'd0, 3'd0, 0, 0, 1, 0);
        tbl[22] = mk(1, 1, 3'd4, 8'h44, 0, 3'd0, 8'h00, 0, 3'd0, 3'd2, 3'd0, 1, 0, 1, 1);
        tbl[23] = mk(1, 1, 3'd7, 8'h70, 1, 3'd6, 8'h60, 0, 3'd0, 3'd0, 3'd0, 1, 0, 1, 0);
        tbl[24] = mk(1, 1, 3'd7, 8'h70, 1, 3'd6, 8'h60, 0, 3'd0, 3'd0, 3'd0, 0, 1, 1, 0);
        tbl[25] = mk(1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, 0);

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        chk("reset_rf_rd", 32'(rf_rd), 32'd0);
        chk("reset_rf_din", 32'(rf_din), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        reset = 1'b0;

        for (int i = 0; i <= 22; i++) step(i);

        // Reset mid-operation with busy[2] set and a write sitting in the output register.
        idle_inputs();
        rs1   = 3'd2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_rf_we", 32'(rf_we), 32'd0);
        chk("midreset_rf_rd", 32'(rf_rd), 32'd0);
        chk("midreset_rf_din", 32'(rf_din), 32'd0);
        chk("midreset_stall", 32'(stall), 32'd0);
        reset    = 1'b0;
        last_rd  = '0;
        last_din = '0;

        for (int i = 23; i <= 25; i++) step(i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
